opcode_inject: RTL and testbench

Bus-side driver that forces a Z80 `JP nn` into the instruction stream. It is the counterpart of the opcode-fetch snooper, which only watches M1 fetches.
- On a trap request it waits for an instruction boundary, then substitutes three bytes for real memory: opcode on the M1 fetch, vector low and vector high on the two operand reads.
- Used by the mapper to redirect the CPU into supervisor code without the CPU's cooperation.

---
 rtl/mm_bus_pkg.sv | 13 +
 rtl/z80_cycle_detect.sv | 23 ++
 rtl/opcode_inject.sv | 108 ++++++++++
 tb/tb_opcode_inject.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mm_bus_pkg.sv
// mm_bus_pkg: shared Z80 bus constants for the injector and the opcode tracker
package mm_bus_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_OP    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_HI    = 3'd4;
  localparam logic [7:0] OP_JP = 8'hC3;
  localparam logic [7:0] OP_CB = 8'hCB;
  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [7:0] OP_DD = 8'hDD;
  localparam logic [7:0] OP_FD = 8'hFD;
endpackage

// File: rtl/z80_cycle_detect.sv
// z80_cycle_detect: rd_n edge detection and M1-fetch / memory-read strobes
module z80_cycle_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic m1_n_i,
  input  logic mreq_n_i,
  input  logic iorq_n_i,
  input  logic rd_n_i,
  output logic fetch_o,
  output logic memrd_o,
  output logic rd_rise_o
);
  logic prev_rd_n_q;
  logic rd_fall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_rd_n_q <= 1'b1;
    else prev_rd_n_q <= rd_n_i;
  assign rd_fall   = prev_rd_n_q & ~rd_n_i;
  assign rd_rise_o = ~prev_rd_n_q & rd_n_i;
  // refresh never pulls rd_n low, so it never produces a strobe
  assign fetch_o   = rd_fall & ~m1_n_i & ~mreq_n_i;
  assign memrd_o   = rd_fall & m1_n_i & ~mreq_n_i & iorq_n_i;
endmodule

// File: rtl/opcode_inject.sv
// opcode_inject: forces a JP nn into the Z80 instruction stream on a trap request
module opcode_inject
  import mm_bus_pkg::*;
#(
  parameter logic [7:0] INJ_OPCODE = OP_JP,
  parameter logic [7:0] TIMEOUT    = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        isr_boundary,
  input  logic        trap_req,
  input  logic        trap_cancel,
  input  logic [15:0] trap_vector,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        mem_inhibit,
  output logic        busy,
  output logic        trap_done,
  output logic        trap_timeout
);
  logic [2:0]  state_q, state_d;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        drv_q, drv_d;
  logic        done_q, done_d;
  logic        to_q, to_d;
  logic        fetch, memrd, rd_rise;

  z80_cycle_detect u_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .m1_n_i    (m1_n),
    .mreq_n_i  (mreq_n),
    .iorq_n_i  (iorq_n),
    .rd_n_i    (rd_n),
    .fetch_o   (fetch),
    .memrd_o   (memrd),
    .rd_rise_o (rd_rise)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (trap_req) begin
        vec_d   = trap_vector;
        state_d = ST_ARMED;
      end
      ST_ARMED: state_d = trap_cancel ? ST_IDLE : (fetch && isr_boundary) ? ST_OP : ST_ARMED;
      ST_OP: if (rd_rise) begin
        cnt_d   = 8'd0;
        state_d = ST_LO;
      end
      ST_LO, ST_HI: if (drv_q) begin
        if (rd_rise) begin
          drv_d   = 1'b0;
          cnt_d   = 8'd0;
          done_d  = state_q == ST_HI;
          state_d = state_q == ST_LO ? ST_HI : ST_IDLE;
        end
      end else if (memrd) begin
        drv_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == TIMEOUT) begin
          cnt_d   = 8'd0;
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 16'h0000;
      cnt_q   <= 8'd0;
      drv_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end

  // combinational from state and rd_n so the byte is on the bus before the T3 sample
  assign data_oe      = ~rd_n & (state_q == ST_OP | drv_q);
  assign data_out     = !data_oe ? 8'h00 : state_q == ST_OP ? INJ_OPCODE :
                        state_q == ST_LO ? vec_q[7:0] : vec_q[15:8];
  assign mem_inhibit  = state_q == ST_OP | state_q == ST_LO | state_q == ST_HI;
  assign busy         = state_q != ST_IDLE;
  assign trap_done    = done_q;
  assign trap_timeout = to_q;
endmodule

// File: tb/tb_opcode_inject.sv
// tb_opcode_inject: scoreboard bench driving Z80 bus cycles through opcode_inject
module tb_opcode_inject;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1;
  logic        isr_boundary = 1'b0, trap_req = 1'b0, trap_cancel = 1'b0;
  logic [15:0] trap_vector = 16'h0000;
  logic [7:0]  data_out;
  logic        data_oe, mem_inhibit, busy, trap_done, trap_timeout;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [8:0]  sb[$];

  always #5 clk = ~clk;

  opcode_inject dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m1_n         (m1_n),
    .mreq_n       (mreq_n),
    .iorq_n       (iorq_n),
    .rd_n         (rd_n),
    .isr_boundary (isr_boundary),
    .trap_req     (trap_req),
    .trap_cancel  (trap_cancel),
    .trap_vector  (trap_vector),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .mem_inhibit  (mem_inhibit),
    .busy         (busy),
    .trap_done    (trap_done),
    .trap_timeout (trap_timeout)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [15:0] v);
    trap_vector = v;
    trap_req = 1'b1;
    tick();
    trap_req = 1'b0;
  endtask

  task automatic push_jp(input logic [15:0] v);
    sb.push_back({1'b1, 8'hC3});
    sb.push_back({1'b1, v[7:0]});
    sb.push_back({1'b1, v[15:8]});
  endtask

  // one read cycle: m1 fetch, io read or plain memory read, with extra wait clocks
  task automatic bus_rd(input bit m1, input bit io, input int waits, input string tag);
    logic [8:0] e;
    m1_n = !m1;
    mreq_n = io;
    iorq_n = !io;
    rd_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
      e = 9'h000;
    end else e = sb.pop_front();
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_oe"}, {15'd0, data_oe}, {15'd0, e[8]});
      if (e[8]) chk({tag, "_data"}, {8'd0, data_out}, {8'd0, e[7:0]});
      if (i < waits) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rd_n = 1'b1;
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    m1_n = 1'b1;
    #1 chk({tag, "_release"}, {15'd0, data_oe}, 16'd0);
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_oe", {15'd0, data_oe}, 16'd0);
    chk("rst_inhibit", {15'd0, mem_inhibit}, 16'd0);
    chk("rst_data", {8'd0, data_out}, 16'd0);
    chk("rst_pulses", {14'd0, trap_done, trap_timeout}, 16'd0);
    rst_n = 1'b1;
    tick();

    isr_boundary = 1'b1;
    req(16'h1234);
    chk("armed_busy", {15'd0, busy}, 16'd1);
    chk("armed_inhibit", {15'd0, mem_inhibit}, 16'd0);
    push_jp(16'h1234);
    bus_rd(1, 0, 0, "basic_op");
    chk("gap_inhibit", {15'd0, mem_inhibit}, 16'd1);
    bus_rd(0, 0, 0, "basic_lo");
    chk("done_early", {15'd0, trap_done}, 16'd0);
    bus_rd(0, 0, 0, "basic_hi");
    chk("basic_done", {15'd0, trap_done}, 16'd1);
    chk("basic_idle", {15'd0, busy}, 16'd0);
    tick();
    chk("basic_done_once", {15'd0, trap_done}, 16'd0);

    isr_boundary = 1'b0;
    req(16'h1234);
    sb.push_back(9'h000);
    bus_rd(1, 0, 0, "prefix_fetch");
    chk("prefix_still_armed", {15'd0, busy}, 16'd1);
    isr_boundary = 1'b1;
    push_jp(16'h1234);
    bus_rd(1, 0, 0, "bnd_op");
    mreq_n = 1'b0;
    @(negedge clk);
    chk("refresh_oe", {15'd0, data_oe}, 16'd0);
    tick();
    mreq_n = 1'b1;
    tick();
    sb.insert(0, 9'h000);
    bus_rd(0, 1, 0, "io_read");
    chk("io_inhibit", {15'd0, mem_inhibit}, 16'd1);
    bus_rd(0, 0, 0, "bnd_lo");
    bus_rd(0, 0, 0, "bnd_hi");
    chk("bnd_done", {15'd0, trap_done}, 16'd1);

    tick();
    req(16'hBEEF);
    sb.push_back({1'b1, 8'hC3});
    bus_rd(1, 0, 0, "to_op");
    repeat (254) tick();
    chk("to_early", {15'd0, trap_timeout}, 16'd0);
    chk("to_busy_early", {15'd0, busy}, 16'd1);
    tick();
    chk("to_pulse", {15'd0, trap_timeout}, 16'd1);
    chk("to_busy", {15'd0, busy}, 16'd0);
    chk("to_oe", {15'd0, data_oe}, 16'd0);
    chk("to_inhibit", {15'd0, mem_inhibit}, 16'd0);
    chk("to_no_done", {15'd0, trap_done}, 16'd0);
    tick();
    chk("to_once", {15'd0, trap_timeout}, 16'd0);

    req(16'h4444);
    trap_cancel = 1'b1;
    sb.push_back(9'h000);
    bus_rd(1, 0, 0, "cancel_fetch");
    trap_cancel = 1'b0;
    chk("cancel_busy", {15'd0, busy}, 16'd0);
    chk("cancel_inhibit", {15'd0, mem_inhibit}, 16'd0);

    req(16'h1234);
    push_jp(16'h1234);
    bus_rd(1, 0, 0, "ws_op");
    bus_rd(0, 0, 0, "ws_lo");
    req(16'hFFFF);
    chk("ws_busy_hi", {15'd0, busy}, 16'd1);
    bus_rd(0, 0, 5, "ws_hi");
    chk("ws_done", {15'd0, trap_done}, 16'd1);
    chk("ws_idle", {15'd0, busy}, 16'd0);
    tick();
    chk("ws_req_dropped", {15'd0, busy}, 16'd0);

    req(16'h1234);
    m1_n = 1'b0;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_oe", {15'd0, data_oe}, 16'd1);
    chk("mid_data", {8'd0, data_out}, 16'h00C3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_oe", {15'd0, data_oe}, 16'd0);
    chk("async_inhibit", {15'd0, mem_inhibit}, 16'd0);
    chk("async_busy", {15'd0, busy}, 16'd0);
    m1_n = 1'b1;
    mreq_n = 1'b1;
    rd_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {15'd0, busy}, 16'd0);
    chk("sb_drained", sb.size()[15:0], 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
